// File: rtl/burst_mem_ctrl.sv
// rtl/burst_mem_ctrl.sv - clocked burst word memory with req/busy/done handshake
//
// Purpose: DEPTH x DATA_W memory that moves LANES words per request, BEAT
// lanes per clock, with wrap-around addressing and registered outputs.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   req       request strobe, accepted only while idle
//   r_w       1 = read, 0 = write
//   single    single-word access (indata on write, lane 0 on read)
//   abus      start address
//   indata    single-write data
//   dbus_in   burst write data, lane i at [i*DATA_W +: DATA_W]
//   dbus_out  registered read data, same packing
//   busy      request in progress
//   done      one-cycle completion pulse
//   rd_valid  one-cycle pulse with done on reads
//   err       sticky range error (RANGE_CHECK_EN builds only)
//
// Optional feature macro: RANGE_CHECK_EN - rejects requests whose span
// runs past DEPTH instead of wrapping, and adds the err port.

module burst_mem_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 2048,
    parameter int LANES  = 50,
    parameter int BEAT   = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    input  logic                    r_w,
    input  logic                    single,
    input  logic [ADDR_W-1:0]       abus,
    input  logic [DATA_W-1:0]       indata,
    input  logic [LANES*DATA_W-1:0] dbus_in,
    output logic [LANES*DATA_W-1:0] dbus_out,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_valid
`ifdef RANGE_CHECK_EN
    ,
    output logic                    err
`endif
);

    localparam int NBEATS = (LANES + BEAT - 1) / BEAT;
    localparam int BCW    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int MAW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0]       abus_q, abus_d;
    logic                    r_w_q, r_w_d;
    logic                    single_q, single_d;
    logic [DATA_W-1:0]       indata_q, indata_d;
    logic [LANES*DATA_W-1:0] dbus_q, dbus_d;
    logic [BCW-1:0]          beat_q, beat_d;
    logic [LANES*DATA_W-1:0] dbus_out_q, dbus_out_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    rd_valid_q, rd_valid_d;

    logic [DATA_W-1:0] mem [DEPTH];

    // Per-beat lane decode: which lanes move this cycle and where they go.
    int                lane_idx  [BEAT];
    logic              lane_act  [BEAT];
    logic [MAW-1:0]    lane_addr [BEAT];
    logic              we        [BEAT];
    logic [DATA_W-1:0] wdata     [BEAT];

    logic last_beat;
    logic reject;

`ifdef RANGE_CHECK_EN
    logic            err_q, err_d;
    logic [ADDR_W:0] span_end;

    // Sum at ADDR_W+1 bits so a start near the top of abus cannot overflow.
    assign span_end = {1'b0, abus} + (single ? (ADDR_W+1)'(1) : (ADDR_W+1)'(LANES));
    assign reject   = (span_end > (ADDR_W+1)'(DEPTH));
    assign err      = err_q;

    always_comb begin
        err_d = err_q | ((state_q == S_IDLE) && req && reject);
    end
`else
    assign reject = 1'b0;
`endif

    always_comb begin
        for (int j = 0; j < BEAT; j++) begin
            logic [ADDR_W:0] sum;
            lane_idx[j]  = int'(beat_q) * BEAT + j;
            lane_act[j]  = single_q ? (j == 0) : (lane_idx[j] < LANES);
            // Reduce mod DEPTH by keeping the low address bits: bursts wrap to 0.
            sum          = {1'b0, abus_q} + (ADDR_W+1)'(lane_idx[j]);
            lane_addr[j] = sum[MAW-1:0];
        end
    end

    assign last_beat = single_q || (beat_q == BCW'(NBEATS - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req) state_d = reject ? S_DONE : S_XFER;
            S_XFER:  if (last_beat) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath logic
    always_comb begin
        abus_d     = abus_q;
        r_w_d      = r_w_q;
        single_d   = single_q;
        indata_d   = indata_q;
        dbus_d     = dbus_q;
        beat_d     = beat_q;
        dbus_out_d = dbus_out_q;
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        // A rejected request reaches DONE straight from IDLE, so no rd_valid.
        rd_valid_d = (state_q == S_XFER) && (state_d == S_DONE) && r_w_q;
        for (int j = 0; j < BEAT; j++) begin
            we[j]    = 1'b0;
            wdata[j] = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    abus_d   = abus;
                    r_w_d    = r_w;
                    single_d = single;
                    indata_d = indata;
                    dbus_d   = dbus_in;
                    beat_d   = '0;
                end
            end
            S_XFER: begin
                beat_d = beat_q + 1'b1;
                if (r_w_q && single_q) begin
                    dbus_out_d = '0;
                end
                for (int j = 0; j < BEAT; j++) begin
                    if (lane_act[j]) begin
                        if (r_w_q) begin
                            dbus_out_d[lane_idx[j]*DATA_W +: DATA_W] = mem[lane_addr[j]];
                        end else begin
                            we[j]    = 1'b1;
                            wdata[j] = single_q ? indata_q
                                                : dbus_q[lane_idx[j]*DATA_W +: DATA_W];
                        end
                    end
                end
                // Writes echo their first word into lane 0 on completion.
                if (!r_w_q && (state_d == S_DONE)) begin
                    dbus_out_d[DATA_W-1:0] = single_q ? indata_q : dbus_q[DATA_W-1:0];
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            abus_q     <= '0;
            r_w_q      <= 1'b0;
            single_q   <= 1'b0;
            indata_q   <= '0;
            dbus_q     <= '0;
            beat_q     <= '0;
            dbus_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
`ifdef RANGE_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            abus_q     <= abus_d;
            r_w_q      <= r_w_d;
            single_q   <= single_d;
            indata_q   <= indata_d;
            dbus_q     <= dbus_d;
            beat_q     <= beat_d;
            dbus_out_q <= dbus_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
`ifdef RANGE_CHECK_EN
            err_q      <= err_d;
`endif
        end
    end

    // Storage is never cleared; write enables are gated by the reset state.
    always_ff @(posedge clk) begin
        for (int j = 0; j < BEAT; j++) begin
            if (we[j]) begin
                mem[lane_addr[j]] <= wdata[j];
            end
        end
    end

    assign dbus_out = dbus_out_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_burst_mem_ctrl.sv
// tb/tb_burst_mem_ctrl.sv - directed self-checking bench for burst_mem_ctrl

module tb_burst_mem_ctrl;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int LN = 50;
    localparam int BW = LN * DW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req = 1'b0;
    logic          r_w = 1'b0;
    logic          single = 1'b0;
    logic [AW-1:0] abus = '0;
    logic [DW-1:0] indata = '0;
    logic [BW-1:0] dbus_in = '0;
    logic [BW-1:0] dbus_out;
    logic          busy;
    logic          done;
    logic          rd_valid;
`ifdef RANGE_CHECK_EN
    logic          err;
`endif

    int total = 0;
    int bad   = 0;

    burst_mem_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .r_w      (r_w),
        .single   (single),
        .abus     (abus),
        .indata   (indata),
        .dbus_in  (dbus_in),
        .dbus_out (dbus_out),
        .busy     (busy),
        .done     (done),
        .rd_valid (rd_valid)
`ifdef RANGE_CHECK_EN
        ,
        .err      (err)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] pat(input logic [DW-1:0] base);
        logic [BW-1:0] r;
        for (int i = 0; i < LN; i++) r[i*DW +: DW] = base + DW'(i);
        return r;
    endfunction

    // Issues one request, then scrambles the inputs to show they are ignored.
    // lat = posedges after the request was driven until done is seen (0 = timeout).
    task automatic do_req(input logic rw, input logic sgl, input logic [AW-1:0] a,
                          input logic [DW-1:0] ind, input logic [BW-1:0] d,
                          output int lat, output logic rdv_done, output logic rdv_stray);
        @(posedge clk); #1;
        req = 1'b1; r_w = rw; single = sgl; abus = a; indata = ind; dbus_in = d;
        lat = 0; rdv_done = 1'b0; rdv_stray = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                req = 1'b0; r_w = ~rw; single = ~sgl; abus = a + 16'd3;
                indata = ~ind; dbus_in = ~d;
            end
            if (done === 1'b1) begin
                lat = k; rdv_done = rd_valid;
                break;
            end
            if (rd_valid !== 1'b0) rdv_stray = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            total++;
            if (busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0 || dbus_out !== '0) begin
                bad++;
                $display("FAIL reset_idle cycle %0d: busy=%b done=%b rd_valid=%b dbus_out=%h, want 0s",
                         c, busy, done, rd_valid, dbus_out);
            end
        end
`ifdef RANGE_CHECK_EN
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL reset_err: got %b want 0", err);
        end
`endif
    endtask

    task automatic test_burst();
        int lat; logic rv, rs; logic [BW-1:0] exp;
        do_req(1'b0, 1'b0, 16'd100, 8'h00, pat(8'h01), lat, rv, rs);
        total++;
        if (lat != 6 || rv !== 1'b0 || rs !== 1'b0) begin
            bad++;
            $display("FAIL burst_wr_lat: lat=%0d rd_valid=%b stray=%b, want 6/0/0", lat, rv, rs);
        end
        exp = '0; exp[7:0] = 8'h01;
        total++;
        if (dbus_out !== exp) begin
            bad++;
            $display("FAIL burst_wr_echo: got %h want %h", dbus_out, exp);
        end
        do_req(1'b1, 1'b0, 16'd100, 8'h00, '0, lat, rv, rs);
        total++;
        if (lat != 6 || rv !== 1'b1 || rs !== 1'b0) begin
            bad++;
            $display("FAIL burst_rd_lat: lat=%0d rd_valid=%b stray=%b, want 6/1/0", lat, rv, rs);
        end
        total++;
        if (dbus_out !== pat(8'h01)) begin
            bad++;
            $display("FAIL burst_rd_data: got %h want %h", dbus_out, pat(8'h01));
        end
    endtask

    task automatic test_single();
        int lat; logic rv, rs; logic [BW-1:0] exp;
        do_req(1'b0, 1'b1, 16'd1000, 8'h10, '1, lat, rv, rs);
        total++;
        if (lat != 2 || rv !== 1'b0) begin
            bad++;
            $display("FAIL single_wr_lat: lat=%0d rd_valid=%b, want 2/0", lat, rv);
        end
        exp = pat(8'h01); exp[7:0] = 8'h10;
        total++;
        if (dbus_out !== exp) begin
            bad++;
            $display("FAIL single_wr_echo: got %h want %h", dbus_out, exp);
        end
        do_req(1'b1, 1'b1, 16'd1000, 8'h00, '0, lat, rv, rs);
        exp = '0; exp[7:0] = 8'h10;
        total++;
        if (lat != 2 || rv !== 1'b1 || dbus_out !== exp) begin
            bad++;
            $display("FAIL single_rd: lat=%0d rd_valid=%b data=%h, want 2/1/%h", lat, rv, dbus_out, exp);
        end
    endtask

    task automatic test_wrap();
        int lat; logic rv, rs; logic [BW-1:0] exp;
`ifdef RANGE_CHECK_EN
        logic [BW-1:0] before;
        do_req(1'b0, 1'b1, 16'd2040, 8'h33, '0, lat, rv, rs);
        do_req(1'b1, 1'b1, 16'd2040, 8'h00, '0, lat, rv, rs);
        before = dbus_out;
        do_req(1'b0, 1'b0, 16'd2040, 8'h00, pat(8'hA0), lat, rv, rs);
        total++;
        if (lat == 0 || rv !== 1'b0 || err !== 1'b1) begin
            bad++;
            $display("FAIL range_reject: lat=%0d rd_valid=%b err=%b, want done/0/1", lat, rv, err);
        end
        total++;
        if (dbus_out !== before) begin
            bad++;
            $display("FAIL range_dbus_hold: got %h want %h", dbus_out, before);
        end
        do_req(1'b1, 1'b1, 16'd2040, 8'h00, '0, lat, rv, rs);
        exp = '0; exp[7:0] = 8'h33;
        total++;
        if (dbus_out !== exp || err !== 1'b1) begin
            bad++;
            $display("FAIL range_mem_kept: data=%h err=%b, want %h/1", dbus_out, err, exp);
        end
`else
        do_req(1'b0, 1'b0, 16'd2040, 8'h00, pat(8'hA0), lat, rv, rs);
        total++;
        if (lat != 6) begin
            bad++;
            $display("FAIL wrap_wr_lat: got %0d want 6", lat);
        end
        do_req(1'b1, 1'b1, 16'd2047, 8'h00, '0, lat, rv, rs);
        exp = '0; exp[7:0] = 8'hA7;
        total++;
        if (dbus_out !== exp) begin
            bad++;
            $display("FAIL wrap_rd_2047: got %h want %h", dbus_out, exp);
        end
        do_req(1'b1, 1'b1, 16'd0, 8'h00, '0, lat, rv, rs);
        exp = '0; exp[7:0] = 8'hA8;
        total++;
        if (dbus_out !== exp) begin
            bad++;
            $display("FAIL wrap_rd_0: got %h want %h", dbus_out, exp);
        end
`endif
    endtask

    task automatic test_busy_overlap();
        int lat; logic rv, rs; int dones; logic [BW-1:0] exp;
        do_req(1'b0, 1'b1, 16'd600, 8'h44, '0, lat, rv, rs);
        @(posedge clk); #1;
        req = 1'b1; r_w = 1'b0; single = 1'b0; abus = 16'd500; dbus_in = pat(8'h20);
        dones = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
            if (k == 1) req = 1'b0;
            if (k == 2) begin
                req = 1'b1; abus = 16'd600; dbus_in = pat(8'h77);
            end
            if (k == 3) req = 1'b0;
        end
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL overlap_done_count: got %0d want 1", dones);
        end
        do_req(1'b1, 1'b0, 16'd500, 8'h00, '0, lat, rv, rs);
        total++;
        if (dbus_out !== pat(8'h20)) begin
            bad++;
            $display("FAIL overlap_first_data: got %h want %h", dbus_out, pat(8'h20));
        end
        do_req(1'b1, 1'b1, 16'd600, 8'h00, '0, lat, rv, rs);
        exp = '0; exp[7:0] = 8'h44;
        total++;
        if (dbus_out !== exp) begin
            bad++;
            $display("FAIL overlap_second_ignored: got %h want %h", dbus_out, exp);
        end
    endtask

    task automatic test_reset_mid_burst();
        int lat; logic rv, rs; logic [BW-1:0] exp;
        do_req(1'b0, 1'b0, 16'd0, 8'h00, pat(8'h55), lat, rv, rs);
        @(posedge clk); #1;
        req = 1'b1; r_w = 1'b0; single = 1'b0; abus = 16'd0; dbus_in = pat(8'hC0);
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || dbus_out !== '0) begin
            bad++;
            $display("FAIL midburst_reset: busy=%b done=%b dbus_out=%h, want 0s", busy, done, dbus_out);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        do_req(1'b1, 1'b0, 16'd0, 8'h00, '0, lat, rv, rs);
        exp = pat(8'h55);
        for (int i = 0; i < 20; i++) exp[i*DW +: DW] = 8'hC0 + DW'(i);
        total++;
        if (lat != 6 || dbus_out !== exp) begin
            bad++;
            $display("FAIL midburst_readback: lat=%0d got %h want %h", lat, dbus_out, exp);
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_single();
        test_wrap();
        test_busy_overlap();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/burst_mem_ctrl.md
Name: burst_mem_ctrl

Overview:
- Clocked, parametrised successor to the combinational 50-lane byte memory in the feature-extraction datapath.
- Stores DATA_W-bit words and moves bursts of LANES words per request, BEAT lanes per clock.
- Adds a req/busy/done handshake, registered outputs, address wrap-around and an optional range check.
- Sits between the image-window loader and the texture-feature pipeline.

Parameters:
- DATA_W, 8, word width in bits.
- ADDR_W, 16, address bus width.
- DEPTH, 2048, words of storage; must be a power of 2 and ≤ 2^ADDR_W.
- LANES, 50, words per burst.
- BEAT, 10, lanes transferred per clock; 1 ≤ BEAT ≤ LANES.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  request strobe; accepted only when busy=0.
- r_w  in  1  1 = read burst, 0 = write.
- single  in  1  with r_w=0: single-word write of indata; with r_w=1: single-word read into lane 0.
- abus  in  ADDR_W  start address.
- indata  in  DATA_W  single-write data.
- dbus_in  in  LANES*DATA_W  burst write data; lane i at bits [i*DATA_W +: DATA_W].
- dbus_out  out  LANES*DATA_W  registered read data, same packing as dbus_in.
- busy  out  1  request in progress.
- done  out  1  one-cycle completion pulse.
- rd_valid  out  1  one-cycle pulse coincident with done on reads.
- err  out  1  sticky range error; exists only with RANGE_CHECK_EN.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; busy=0, done=0, rd_valid=0, err=0, dbus_out=0.
  - Memory array is not cleared.
  - Reset mid-burst aborts it; words already written stay written.
- States: IDLE, XFER, DONE.
- IDLE:
  - On req=1, capture abus, r_w, single, indata and the whole of dbus_in into internal registers.
  - Clear beat counter; busy=1 on the next edge; go to XFER.
  - Inputs are sampled only at acceptance; later changes are ignored.
- XFER:
  - Each cycle transfers lanes beat*BEAT .. min(beat*BEAT+BEAT, LANES)-1.
  - Lane i uses address (abus_q + i) mod DEPTH, so bursts wrap past DEPTH-1 to 0.
  - Write: mem[addr] <= captured lane data.
  - Read: dbus_out lane i <= mem[addr]. Each read is synchronous and sees memory as of that edge.
  - NBEATS = ceil(LANES/BEAT); the final beat may be partial.
  - single=1: exactly one beat of one word at abus_q.
- After the last beat, go to DONE: done=1 for one cycle; rd_valid=1 if read; busy=0 on the following edge; return to IDLE.
- Latency, req edge to done high: NBEATS+1 cycles for a burst, 2 cycles for single.
- req while busy=1 is ignored, not queued; the requester must hold or re-issue it.
- Read burst: dbus_out lanes update beat by beat and are stable from done until the next read.
- Single read: lane 0 gets mem[abus_q]; lanes 1..LANES-1 are cleared to 0.
- Write completion: lane 0 of dbus_out gets the first written word (indata or dbus_in lane 0); other lanes are unchanged. This echo is kept for compatibility.
- Address arithmetic is done at ADDR_W+1 bits, then reduced mod DEPTH.
- abus ≥ DEPTH wraps mod DEPTH, unless range checking is compiled in.

Optional Feature:
- Macro: RANGE_CHECK_EN.
- Defined:
  - At acceptance, if abus + span > DEPTH (span = 1 for single, LANES otherwise), the request is rejected.
  - No memory access; go straight to DONE; done pulses; rd_valid stays 0; dbus_out is unchanged; err sets to 1.
  - err clears only on reset.
- Undefined: the err port is absent and all addresses wrap mod DEPTH.

Test Plan:
- Reset then idle: after reset=1, busy=0, done=0, dbus_out=0 held for 10 cycles with req=0.
- Burst write abus=100, lane i = i+1, then burst read abus=100 (defaults): done 6 cycles after each req; dbus_out lane i = i+1; rd_valid pulses with the read's done only.
- Single write abus=1000, indata=0x10; then single read 1000: lane 0 = 0x10, lanes 1..49 = 0, done 2 cycles after each req.
- Wrap: burst write abus=2040, lane i = 0xA0+i; single reads at 2047 → 0xA7 and at 0 → 0xA8. With RANGE_CHECK_EN the write is instead rejected: err=1, done pulses, and address 2040 is unchanged.
- Busy overlap: second req issued 2 cycles into a burst is ignored; exactly one done pulse is seen; memory reflects the first request only.
- Reset mid-burst: reset=0 during beat 3 of a write at 0 → busy=0 immediately; lanes 0..19 written, lanes 20..49 untouched (read back after re-enable).
